p405s_timer_pit_status: RTL and testbench
=========================================

# p405s_timer_pit_status

Timer status and interrupt-delivery block for the PIT and FIT timers. It consumes the single-cycle hardware set pulses from the timer equation logic and holds the PIS/FIS status bits of the TSR. Software clears those bits with a write-one-to-clear mtSPR. The block raises a level interrupt request to the exception unit and holds it through a request/acknowledge handshake. It sits between the timer equation/counter logic and the core exception unit.

## Interface
Parameters: none.

- CB  in  1  core clock; all state is updated on the rising edge.
- coreReset  in  1  asynchronous, active-high reset.
- hwSetPitStatus  in  1  one-cycle pulse: PIT decremented from 1 to 0.
- hwSetFitStatus  in  1  one-cycle pulse: FIT tap transition.
- PCL_mtSPR  in  1  mtSPR in progress.
- PCL_sprHold  in  1  SPR pipeline hold; blocks the write.
- tsrDcd  in  1  SPR number decodes to TSR.
- sprDataIn  in  [0:31]  mtSPR data. Bit 4 = PIS, 5 = FIS, 6 = PIT overrun, 7 = FIT overrun; all other bits ignored.
- tcrPIE  in  1  PIT interrupt enable.
- tcrFIE  in  1  FIT interrupt enable.
- EXU_timerIntAck  in  1  one-cycle acknowledge from the exception unit.
- tsrPis, tsrFis  out  1  status bits.
- tsrPitOvr, tsrFitOvr  out  1  sticky overrun bits.
- timerIntReq  out  1  interrupt request level.
- timerIntVec  out  [0:1]  source of the request: 10 = PIT, 01 = FIT, 00 = none.

## Operation
- tsrWrite = PCL_mtSPR & tsrDcd & ~PCL_sprHold.
- Status bit update, per source (PIT uses bits 4 and 6; FIT uses bits 5 and 7):
  - A set pulse sets the status bit.
  - tsrWrite with a 1 in the status bit position clears it.
  - When set and clear occur in the same cycle, set wins, so no event is lost.
- Overrun bit: set when a set pulse arrives while the status bit is already 1 and is not being cleared in that cycle. Cleared by a W1C write to bit 6 or 7. Set wins over clear here as well.
- Pending: pitPend = tsrPis & tcrPIE; fitPend = tsrFis & tcrFIE. PIT has priority over FIT.
- Request FSM, 2-bit state plus a 1-bit latched source:
  - IDLE:
    - If pitPend or fitPend, go to REQ and latch the winning source.
  - REQ:
    - timerIntReq = 1 and timerIntVec = latched source. The source is frozen for the whole REQ interval.
    - If EXU_timerIntAck, go to WAIT_CLR.
    - Otherwise, if the latched source's pending drops (software clear or mask), go to IDLE. This retraction is legal only before ack.
    - Ack and drop in the same cycle: ack wins, go to WAIT_CLR.
  - WAIT_CLR:
    - timerIntReq = 0.
    - Go to IDLE when the latched source's pending is 0.
    - The other source's pending is ignored until the return to IDLE.
- EXU_timerIntAck outside REQ is ignored.
- Ack never clears status; only a software W1C write does.

## Timing
- Reset values: tsrPis = tsrFis = tsrPitOvr = tsrFitOvr = 0, timerIntReq = 0, timerIntVec = 00, state = IDLE.
- Reset asserted mid-handshake aborts immediately; any pending ack is lost.
- All outputs are registered; there is no combinational path from any input to any output.
- Set pulse at cycle N: status visible at N+1, timerIntReq at N+2 (IDLE, enable already on).
- W1C write at cycle N: status 0 at N+1. If in REQ, timerIntReq drops at N+2.
- Ack at cycle N: timerIntReq = 0 at N+1 (state WAIT_CLR).
- Enable raised at N while status is already 1: timerIntReq at N+1.
- timerIntVec is 00 whenever timerIntReq = 0.

## Test plan
- Reset, enables on, hwSetPitStatus pulse at cycle 10 -> tsrPis = 1 at 11, timerIntReq = 1 and vec = 10 at 12. Ack at 15 -> req = 0 at 16. W1C 0x0800_0000 at 20 -> tsrPis = 0 at 21, FSM back in IDLE at 22.
- PIT and FIT pulses in the same cycle -> vec = 10 first. After ack and PIT clear, req returns with vec = 01 two cycles after the clear.
- PIT pulse and W1C of bit 4 in the same cycle -> tsrPis stays 1 and tsrPitOvr stays 0.
- Second PIT pulse while tsrPis = 1 -> tsrPitOvr = 1. W1C 0x0200_0000 -> tsrPitOvr = 0 and tsrPis unchanged.
- In REQ, drop tcrPIE -> req deasserts within 1 cycle, tsrPis remains 1. Re-enable -> req reasserts next cycle.
- Assert coreReset asynchronously while in WAIT_CLR -> all outputs 0 immediately. Ack pulses with no request pending -> no effect.

Source files
------------

// File: rtl/p405s_timer_pit_status.sv
// rtl/p405s_timer_pit_status.sv - PIT/FIT status bits, overrun tracking and interrupt request handshake
// Holds TSR PIS/FIS plus their sticky overrun bits and drives the timer interrupt request to the exception unit.
module p405s_timer_pit_status (
   input  logic        CB,
   input  logic        coreReset,
   input  logic        hwSetPitStatus,
   input  logic        hwSetFitStatus,
   input  logic        PCL_mtSPR,
   input  logic        PCL_sprHold,
   input  logic        tsrDcd,
   input  logic [0:31] sprDataIn,
   input  logic        tcrPIE,
   input  logic        tcrFIE,
   input  logic        EXU_timerIntAck,
   output logic        tsrPis,
   output logic        tsrFis,
   output logic        tsrPitOvr,
   output logic        tsrFitOvr,
   output logic        timerIntReq,
   output logic [0:1]  timerIntVec
);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      REQ      = 2'b01,
      WAIT_CLR = 2'b10
   } state_t;

   state_t state;
   logic   src_pit;

   logic tsr_write;
   logic clr_pis, clr_fis, clr_pit_ovr, clr_fit_ovr;
   logic set_pit_ovr, set_fit_ovr;
   logic pit_pend, fit_pend, src_pend;
   logic unused_spr_bits;

   assign tsr_write   = PCL_mtSPR & tsrDcd & ~PCL_sprHold;
   assign clr_pis     = tsr_write & sprDataIn[4];
   assign clr_fis     = tsr_write & sprDataIn[5];
   assign clr_pit_ovr = tsr_write & sprDataIn[6];
   assign clr_fit_ovr = tsr_write & sprDataIn[7];

   // A pulse landing on an already-set bit is an overrun unless software is clearing that bit now.
   assign set_pit_ovr = hwSetPitStatus & tsrPis & ~clr_pis;
   assign set_fit_ovr = hwSetFitStatus & tsrFis & ~clr_fis;

   assign pit_pend = tsrPis & tcrPIE;
   assign fit_pend = tsrFis & tcrFIE;
   assign src_pend = src_pit ? pit_pend : fit_pend;

   assign unused_spr_bits = ^{sprDataIn[0:3], sprDataIn[8:31]};

   // Set always beats a simultaneous W1C so no hardware event is dropped.
   always_ff @(posedge CB or posedge coreReset) begin
      if (coreReset) begin
         tsrPis    <= 1'b0;
         tsrFis    <= 1'b0;
         tsrPitOvr <= 1'b0;
         tsrFitOvr <= 1'b0;
      end else begin
         tsrPis    <= hwSetPitStatus | (tsrPis & ~clr_pis);
         tsrFis    <= hwSetFitStatus | (tsrFis & ~clr_fis);
         tsrPitOvr <= set_pit_ovr | (tsrPitOvr & ~clr_pit_ovr);
         tsrFitOvr <= set_fit_ovr | (tsrFitOvr & ~clr_fit_ovr);
      end
   end

   // Request handshake; the source is frozen from entry to REQ until the FSM is back in IDLE.
   always_ff @(posedge CB or posedge coreReset) begin
      if (coreReset) begin
         state       <= IDLE;
         src_pit     <= 1'b0;
         timerIntReq <= 1'b0;
         timerIntVec <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (pit_pend | fit_pend) begin
                  state       <= REQ;
                  src_pit     <= pit_pend;
                  timerIntReq <= 1'b1;
                  timerIntVec <= pit_pend ? 2'b10 : 2'b01;
               end
            end
            REQ: begin
               if (EXU_timerIntAck) begin
                  state       <= WAIT_CLR;
                  timerIntReq <= 1'b0;
                  timerIntVec <= 2'b00;
               end else if (!src_pend) begin
                  state       <= IDLE;
                  timerIntReq <= 1'b0;
                  timerIntVec <= 2'b00;
               end
            end
            WAIT_CLR: begin
               if (!src_pend) begin
                  state <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               timerIntReq <= 1'b0;
               timerIntVec <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_p405s_timer_pit_status.sv
// tb/tb_p405s_timer_pit_status.sv - directed and randomized bench for p405s_timer_pit_status
// A behavioural model of the TSR and interrupt handshake predicts every output each cycle.
module tb_p405s_timer_pit_status;

   logic        CB = 1'b0;
   logic        coreReset = 1'b1;
   logic        hwSetPitStatus = 1'b0;
   logic        hwSetFitStatus = 1'b0;
   logic        PCL_mtSPR = 1'b0;
   logic        PCL_sprHold = 1'b0;
   logic        tsrDcd = 1'b0;
   logic [0:31] sprDataIn = 32'h0;
   logic        tcrPIE = 1'b0;
   logic        tcrFIE = 1'b0;
   logic        EXU_timerIntAck = 1'b0;
   logic        tsrPis, tsrFis, tsrPitOvr, tsrFitOvr, timerIntReq;
   logic [0:1]  timerIntVec;

   int tests = 0;
   int fails = 0;

   // Model: status/overrun flags plus the handshake phase (0 quiet, 1 requesting, 2 awaiting clear).
   bit       m_pis, m_fis, m_povr, m_fovr;
   int       m_phase;
   bit       m_src_is_pit;

   p405s_timer_pit_status dut (
      .CB(CB), .coreReset(coreReset),
      .hwSetPitStatus(hwSetPitStatus), .hwSetFitStatus(hwSetFitStatus),
      .PCL_mtSPR(PCL_mtSPR), .PCL_sprHold(PCL_sprHold), .tsrDcd(tsrDcd),
      .sprDataIn(sprDataIn), .tcrPIE(tcrPIE), .tcrFIE(tcrFIE),
      .EXU_timerIntAck(EXU_timerIntAck),
      .tsrPis(tsrPis), .tsrFis(tsrFis), .tsrPitOvr(tsrPitOvr), .tsrFitOvr(tsrFitOvr),
      .timerIntReq(timerIntReq), .timerIntVec(timerIntVec)
   );

   always #5 CB = ~CB;

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pis = 0; m_fis = 0; m_povr = 0; m_fovr = 0;
      m_phase = 0; m_src_is_pit = 0;
   endtask

   task automatic model_edge();
      bit wr, pit_pend, fit_pend, src_pend;
      bit n_pis, n_fis, n_povr, n_fovr;
      if (coreReset) begin
         model_reset();
         return;
      end
      wr       = PCL_mtSPR && tsrDcd && !PCL_sprHold;
      pit_pend = m_pis && tcrPIE;
      fit_pend = m_fis && tcrFIE;
      src_pend = m_src_is_pit ? pit_pend : fit_pend;
      n_pis  = hwSetPitStatus || (m_pis && !(wr && sprDataIn[4]));
      n_fis  = hwSetFitStatus || (m_fis && !(wr && sprDataIn[5]));
      n_povr = (hwSetPitStatus && m_pis && !(wr && sprDataIn[4])) || (m_povr && !(wr && sprDataIn[6]));
      n_fovr = (hwSetFitStatus && m_fis && !(wr && sprDataIn[5])) || (m_fovr && !(wr && sprDataIn[7]));
      if (m_phase == 0) begin
         if (pit_pend || fit_pend) begin
            m_phase = 1;
            m_src_is_pit = pit_pend;
         end
      end else if (m_phase == 1) begin
         if (EXU_timerIntAck) m_phase = 2;
         else if (!src_pend) m_phase = 0;
      end else begin
         if (!src_pend) m_phase = 0;
      end
      m_pis = n_pis; m_fis = n_fis; m_povr = n_povr; m_fovr = n_fovr;
   endtask

   task automatic check_all(input string tag);
      logic [1:0] exp_vec;
      exp_vec = (m_phase == 1) ? (m_src_is_pit ? 2'b10 : 2'b01) : 2'b00;
      check({tag, ".pis"},  {1'b0, tsrPis},      {1'b0, m_pis});
      check({tag, ".fis"},  {1'b0, tsrFis},      {1'b0, m_fis});
      check({tag, ".povr"}, {1'b0, tsrPitOvr},   {1'b0, m_povr});
      check({tag, ".fovr"}, {1'b0, tsrFitOvr},   {1'b0, m_fovr});
      check({tag, ".req"},  {1'b0, timerIntReq}, {1'b0, m_phase == 1});
      check({tag, ".vec"},  timerIntVec,         exp_vec);
   endtask

   task automatic clear_pulses();
      hwSetPitStatus = 0; hwSetFitStatus = 0;
      PCL_mtSPR = 0; tsrDcd = 0; PCL_sprHold = 0; sprDataIn = 32'h0;
      EXU_timerIntAck = 0;
   endtask

   task automatic tick(input string tag);
      @(posedge CB);
      model_edge();
      #1;
      check_all(tag);
      clear_pulses();
   endtask

   task automatic w1c(input logic [31:0] data);
      PCL_mtSPR = 1; tsrDcd = 1; PCL_sprHold = 0; sprDataIn = data;
   endtask

   initial begin
      model_reset();
      repeat (3) tick("reset");
      check("reset.req", {1'b0, timerIntReq}, 2'b00);
      check("reset.vec", timerIntVec, 2'b00);
      coreReset = 0;
      tcrPIE = 1; tcrFIE = 1;
      tick("idle");

      // PIT pulse -> status, request, ack, W1C
      hwSetPitStatus = 1;
      tick("pit_set");
      check("pit_set.pis_const", {1'b0, tsrPis}, 2'b01);
      tick("pit_req");
      check("pit_req.req_const", {1'b0, timerIntReq}, 2'b01);
      check("pit_req.vec_const", timerIntVec, 2'b10);
      tick("pit_hold");
      EXU_timerIntAck = 1;
      tick("pit_ack");
      check("pit_ack.req_const", {1'b0, timerIntReq}, 2'b00);
      tick("pit_wait");
      w1c(32'h0800_0000);
      tick("pit_w1c");
      check("pit_w1c.pis_const", {1'b0, tsrPis}, 2'b00);
      repeat (2) tick("pit_idle");

      // PIT and FIT together: PIT first, FIT after PIT is retired
      hwSetPitStatus = 1; hwSetFitStatus = 1;
      tick("both_set");
      tick("both_req");
      check("both_req.vec_const", timerIntVec, 2'b10);
      EXU_timerIntAck = 1;
      tick("both_ack");
      w1c(32'h0800_0000);
      tick("both_clr");
      tick("both_idle");
      tick("fit_req");
      check("fit_req.vec_const", timerIntVec, 2'b01);
      EXU_timerIntAck = 1;
      tick("fit_ack");
      w1c(32'h0400_0000);
      repeat (3) tick("fit_clr");

      // Set and W1C of PIS together: set wins, no overrun
      hwSetPitStatus = 1; w1c(32'h0800_0000);
      tick("set_vs_clr");
      check("set_vs_clr.pis_const", {1'b0, tsrPis}, 2'b01);
      check("set_vs_clr.ovr_const", {1'b0, tsrPitOvr}, 2'b00);
      tick("ovr_pre");

      // Second pulse while PIS set -> overrun, then W1C of overrun only
      hwSetPitStatus = 1;
      tick("ovr_set");
      check("ovr_set.ovr_const", {1'b0, tsrPitOvr}, 2'b01);
      w1c(32'h0200_0000);
      tick("ovr_clr");
      check("ovr_clr.ovr_const", {1'b0, tsrPitOvr}, 2'b00);
      check("ovr_clr.pis_const", {1'b0, tsrPis}, 2'b01);

      // Mask retraction in REQ, then re-enable
      tcrPIE = 0;
      tick("mask_drop");
      check("mask_drop.req_const", {1'b0, timerIntReq}, 2'b00);
      tcrPIE = 1;
      tick("mask_reen");
      check("mask_reen.req_const", {1'b0, timerIntReq}, 2'b01);

      // Async reset in WAIT_CLR
      EXU_timerIntAck = 1;
      tick("pre_rst_ack");
      #2 coreReset = 1;
      #1;
      model_reset();
      check_all("async_rst");
      check("async_rst.req_const", {1'b0, timerIntReq}, 2'b00);
      tick("rst_hold");
      coreReset = 0;
      EXU_timerIntAck = 1;
      tick("stray_ack");
      EXU_timerIntAck = 1;
      tick("stray_ack2");
      check("stray_ack.req_const", {1'b0, timerIntReq}, 2'b00);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         hwSetPitStatus  = ($urandom_range(0, 7) == 0);
         hwSetFitStatus  = ($urandom_range(0, 7) == 0);
         PCL_mtSPR       = ($urandom_range(0, 5) == 0);
         tsrDcd          = ($urandom_range(0, 3) != 0);
         PCL_sprHold     = ($urandom_range(0, 4) == 0);
         sprDataIn       = $urandom;
         EXU_timerIntAck = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) tcrPIE = ~tcrPIE;
         if ($urandom_range(0, 15) == 0) tcrFIE = ~tcrFIE;
         coreReset       = ($urandom_range(0, 299) == 0);
         tick("rand");
      end
      coreReset = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
